// File: rtl/paralelo_serial.sv
// paralelo_serial: transmit-side lane serializer.
// Link-layer bytes enter through a valid/ready handshake into a small FIFO and
// leave MSB first, one bit per clk_32f, in 8-bit slots. After reset a preamble
// of comma symbols is sent. Empty slots carry the comma symbol so the receiver
// keeps symbol lock. Bytes equal to the comma value are accepted and discarded.

module paralelo_serial #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_COMMAS = 4,
    parameter logic [7:0] COMMA       = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       tx_active,
    output logic       bc_drop
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int SYNC_W = (SYNC_COMMAS > 0) ? $clog2(SYNC_COMMAS + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COMMAS);

    // ST_SYNC: preamble commas only. ST_DATA: slots may carry FIFO bytes.
    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Serializer state
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_byte_cur;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic              r_data_out;
    logic              r_bc_drop;

    // Input FIFO
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Combinational helpers
    logic              w_ready;
    logic              w_accept;
    logic              w_is_comma;
    logic              w_push;
    logic              w_pop;
    logic              w_slot_end;
    logic              w_fifo_empty;
    logic [7:0]        w_head;
    logic [7:0]        w_byte_nxt;
    logic [SYNC_W-1:0] w_sync_nxt;
    logic [CNT_W-1:0]  w_count_nxt;

    // Handshake and FIFO status decode (registered count only, no input path).
    assign w_ready      = (r_count < CNT_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_accept     = valid_in && w_ready;
    assign w_is_comma   = (data_in == COMMA);
    assign w_push       = w_accept && !w_is_comma;
    assign w_slot_end   = (r_bit_cnt == 3'd7);
    assign w_head       = r_mem[r_rd_ptr];

    // Slot scheduler: picks the byte for the next slot and the next FSM state.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte_cur;
        w_sync_nxt  = r_sync_cnt;
        w_pop       = 1'b0;

        if (w_slot_end) begin
            if (r_sync_cnt < SYNC_LAST) begin
                // Still inside the preamble: another comma.
                w_byte_nxt = COMMA;
                w_sync_nxt = r_sync_cnt + 1'b1;
            end else if (!w_fifo_empty) begin
                // Pop decision uses the pre-edge count, so a byte pushed on
                // this same edge into an empty FIFO waits for the next slot.
                w_byte_nxt = w_head;
                w_pop      = 1'b1;
            end else begin
                w_byte_nxt = COMMA;
            end
        end

        case (r_state)
            ST_SYNC: begin
                if (w_slot_end && (r_sync_cnt == SYNC_LAST)) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_state_nxt = ST_DATA;
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // FIFO occupancy bookkeeping for the current edge.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FSM state register; reset restarts the preamble.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serial shifter: one bit per clock, MSB first; reset aborts the slot and
    // reloads a comma that counts as preamble symbol 1.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_data_out <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cur <= COMMA;
            r_sync_cnt <= SYNC_W'(1);
        end else begin
            r_data_out <= r_byte_cur[3'd7 - r_bit_cnt];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_byte_cur <= w_byte_nxt;
            r_sync_cnt <= w_sync_nxt;
        end
    end

    // FIFO pointers and count; reset flushes any queued bytes.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_32f) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Comma filter flag: one-cycle pulse after a comma-valued byte is accepted.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_bc_drop <= 1'b0;
        end else begin
            r_bc_drop <= w_accept && w_is_comma;
        end
    end

    assign ready_out = w_ready;
    assign data_out  = r_data_out;
    assign tx_active = (r_state == ST_DATA);
    assign bc_drop   = r_bc_drop;

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: drives link-layer bytes, queues the bytes expected
// on the line, rebuilds slots from the serial stream and compares.

module tb_paralelo_serial;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;
    logic       data_out;
    logic       tx_active;
    logic       bc_drop;

    int         n_total = 0;
    int         n_bad   = 0;
    int         tb_cyc  = 0;
    int         acc_cyc = 0;
    logic [7:0] sh      = 8'h00;
    logic [7:0] slots [64];
    logic [7:0] exp_q [$];

    paralelo_serial #(
        .FIFO_DEPTH (4),
        .SYNC_COMMAS(4),
        .COMMA      (8'hBC)
    ) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .valid_in (valid_in),
        .data_in  (data_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .tx_active(tx_active),
        .bc_drop  (bc_drop)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    // Cycle index since reset release: posedge n drives bit n of the stream.
    always @(posedge clk_32f) begin
        tb_cyc <= reset ? tb_cyc + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, tb_cyc);
        end
    endtask

    function automatic logic [7:0] slot_at(input int k);
        return slots[6'(k)];
    endfunction

    // Advance one cycle, then sample the serial line and close slots.
    task automatic tick();
        int slot;
        @(negedge clk_32f);
        if (tb_cyc == 0) begin
            sh    = 8'h00;
            slots = '{default: 8'h00};
        end else begin
            sh = {sh[6:0], data_out};
            if (((tb_cyc - 1) % 8) == 7) begin
                slot = (tb_cyc - 1) / 8;
                slots[6'(slot)] = sh;
                if (sh != COMMA) begin
                    if (exp_q.size() > 0) chk("line_byte", 32'(sh), 32'(exp_q.pop_front()));
                    else                  chk("line_byte_unexpected", 32'(sh), 32'hFFFF_FFFF);
                end
            end
        end
    endtask

    task automatic wait_to(input int n);
        int g;
        g = 0;
        while (tb_cyc < n && g < 2000) begin
            tick();
            g++;
        end
        if (tb_cyc < n) chk("wait_timeout", 32'(tb_cyc), 32'(n));
    endtask

    // Offer a byte and hold it until the DUT takes it.
    task automatic push(input logic [7:0] b);
        int w;
        w        = 0;
        valid_in = 1'b1;
        data_in  = b;
        while (!ready_out && w < 200) begin
            tick();
            w++;
        end
        if (!ready_out) chk("push_timeout", 32'(ready_out), 32'd1);
        acc_cyc = tb_cyc + 1;
        if (b != COMMA) exp_q.push_back(b);
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_tx_active", 32'(tx_active), 32'd0);
        chk("rst_bc_drop",   32'(bc_drop),   32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        reset = 1'b1;

        // Preamble with no input, then one mid-slot byte
        wait_to(31);
        chk("tx_active_c31", 32'(tx_active), 32'd0);
        tick();
        chk("tx_active_c32", 32'(tx_active), 32'd1);
        wait_to(43);
        push(8'hA5);
        chk("a5_ready_out", 32'(ready_out), 32'd1);
        wait_to(65);
        for (int k = 0; k < 6; k++) chk("idle_comma_slot", 32'(slot_at(k)), 32'(COMMA));
        chk("a5_slot6", 32'(slot_at(6)), 32'hA5);
        chk("a5_slot7_idle", 32'(slot_at(7)), 32'(COMMA));

        // Fill FIFO during the preamble, hold a fifth byte while full
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        wait_to(2);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("full_ready_out", 32'(ready_out), 32'd0);
        push(8'h55);
        chk("55_accept_cycle", 32'(acc_cyc), 32'd33);
        wait_to(73);
        chk("preamble_slot3", 32'(slot_at(3)), 32'(COMMA));
        chk("first_data_slot4", 32'(slot_at(4)), 32'h11);
        chk("last_data_slot8", 32'(slot_at(8)), 32'h55);

        // Comma filter
        wait_to(74);
        chk("bc_drop_idle", 32'(bc_drop), 32'd0);
        push(8'hBC);
        chk("bc_drop_pulse", 32'(bc_drop), 32'd1);
        chk("bc_ready_out", 32'(ready_out), 32'd1);
        push(8'h3C);
        chk("bc_drop_end", 32'(bc_drop), 32'd0);
        wait_to(89);
        chk("filter_slot9", 32'(slot_at(9)), 32'(COMMA));
        chk("filter_slot10", 32'(slot_at(10)), 32'h3C);

        // Push on the slot boundary edge with an empty FIFO
        wait_to(95);
        push(8'h5A);
        chk("edge_accept_cycle", 32'(acc_cyc), 32'd96);
        wait_to(113);
        chk("edge_slot12_comma", 32'(slot_at(12)), 32'(COMMA));
        chk("edge_slot13_data", 32'(slot_at(13)), 32'h5A);

        // Reset at bit 3 of a data slot with two bytes queued
        wait_to(114);
        push(8'h12);
        push(8'h34);
        push(8'h56);
        wait_to(123);
        reset = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_data_out",  32'(data_out),  32'd0);
        chk("midrst_tx_active", 32'(tx_active), 32'd0);
        chk("midrst_ready_out", 32'(ready_out), 32'd1);
        reset = 1'b1;
        wait_to(31);
        chk("resync_tx_c31", 32'(tx_active), 32'd0);
        tick();
        chk("resync_tx_c32", 32'(tx_active), 32'd1);
        wait_to(81);
        for (int k = 0; k < 10; k++) chk("resync_comma_slot", 32'(slot_at(k)), 32'(COMMA));

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
